// File: rtl/periph_bus_master.sv
// rtl/periph_bus_master.sv - queued request master issuing single-cycle peripheral bus strobes
module periph_bus_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] sys_w_addr,
  output logic [31:0] sys_w_line,
  output logic        sys_w,
  output logic [31:0] sys_r_addr,
  output logic        sys_r,
  input  logic [31:0] sys_r_line,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_e;

  state_e          state_q, state_d;
  logic [64:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            push, pop;
  logic [64:0]     head;
  logic            head_we;
  logic [31:0]     head_addr, head_wdata;

  logic            sys_w_q, sys_r_q, rsp_valid_q, busy_q;
  logic [31:0]     sys_w_addr_q, sys_w_line_q, sys_r_addr_q, rsp_rdata_q;

  assign head       = mem_q[rd_ptr_q];
  assign head_we    = head[64];
  assign head_addr  = head[63:32];
  assign head_wdata = head[31:0];

  // Ready comes from registered occupancy only, so a full queue refuses a push even on a popping edge.
  assign req_ready = ~rst & (count_q != FULL_CNT);
  assign push      = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE, WRITE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = head_we ? WRITE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ:    state_d = RWAIT;
      RWAIT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_we, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sys_w_q      <= 1'b0;
      sys_r_q      <= 1'b0;
      sys_w_addr_q <= '0;
      sys_w_line_q <= '0;
      sys_r_addr_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Strobes are registered at the pop so they coincide with the WRITE/READ state cycle.
      sys_w_q  <= pop & head_we;
      sys_r_q  <= pop & ~head_we;
      if (pop & head_we) begin
        sys_w_addr_q <= head_addr;
        sys_w_line_q <= head_wdata;
      end
      if (pop & ~head_we) begin
        sys_r_addr_q <= head_addr;
      end
      rsp_valid_q <= (state_q == RWAIT);
      if (state_q == RWAIT) begin
        rsp_rdata_q <= sys_r_line;
      end
      busy_q <= (count_d != '0) | (state_d != IDLE);
    end
  end

  assign sys_w      = sys_w_q;
  assign sys_r      = sys_r_q;
  assign sys_w_addr = sys_w_addr_q;
  assign sys_w_line = sys_w_line_q;
  assign sys_r_addr = sys_r_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// tb/tb_periph_bus_master.sv - bench for periph_bus_master with peripheral model and ordered scoreboard
module tb_periph_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] sys_w_addr, sys_w_line, sys_r_addr, sys_r_line;
  logic        sys_w, sys_r, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t bus_log[$];
  ev_t rsp_log[$];
  ev_t sent[$];
  int  cyc     = 0;
  int  overlap = 0;

  bit [31:0] pmem [256];
  bit        pvld [256];
  bit [31:0] mmem [256];
  bit        mvld [256];

  always #5 clk = ~clk;

  periph_bus_master #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .sys_w_addr (sys_w_addr),
    .sys_w_line (sys_w_line),
    .sys_w      (sys_w),
    .sys_r_addr (sys_r_addr),
    .sys_r      (sys_r),
    .sys_r_line (sys_r_line),
    .busy       (busy)
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h11) ? 32'h0000_00FF : (32'hC0DE_0000 | a);
  endfunction

  // Reference memory: requests take effect strictly in push order.
  function automatic logic [31:0] model_step(input bit we, input logic [31:0] a, input logic [31:0] d);
    if (we) begin
      mmem[a[7:0]] = d;
      mvld[a[7:0]] = 1'b1;
      return d;
    end
    return mvld[a[7:0]] ? mmem[a[7:0]] : init_val(a);
  endfunction

  // Peripheral returns read data registered one cycle after the read strobe.
  always @(posedge clk) begin
    if (sys_w) begin
      pmem[sys_w_addr[7:0]] <= sys_w_line;
      pvld[sys_w_addr[7:0]] <= 1'b1;
    end
    if (sys_r) begin
      sys_r_line <= pvld[sys_r_addr[7:0]] ? pmem[sys_r_addr[7:0]] : init_val(sys_r_addr);
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sys_w && sys_r) overlap = overlap + 1;
    if (sys_w) bus_log.push_back('{we: 1'b1, addr: sys_w_addr, data: sys_w_line, cyc: cyc});
    if (sys_r) bus_log.push_back('{we: 1'b0, addr: sys_r_addr, data: 32'h0, cyc: cyc});
    if (rsp_valid) rsp_log.push_back('{we: 1'b0, addr: 32'h0, data: rsp_rdata, cyc: cyc});
  end

  task automatic send(input bit we, input logic [31:0] a, input logic [31:0] d, output int waits);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    waits = n;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout addr=%h ready=%b exp=1", a, req_ready);
    end else begin
      sent.push_back('{we: we, addr: a, data: d, cyc: 0});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 300);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_timeout busy=%b exp=0", name, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b exp=0", req_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({sys_w, sys_r, rsp_valid, busy, req_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00001 (w,r,rsp,busy,ready)", {sys_w, sys_r, rsp_valid, busy, req_ready});
    end
    total++;
    if ({sys_w_addr, sys_w_line, sys_r_addr, rsp_rdata} !== 128'h0) begin
      bad++;
      $display("FAIL reset_data got=%h %h %h %h exp=0", sys_w_addr, sys_w_line, sys_r_addr, rsp_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_write();
    int w;
    send(1'b1, 32'h10, 32'hA5A5_A5A5, w);
    void'(model_step(1'b1, 32'h10, 32'hA5A5_A5A5));
    @(negedge clk);
    total++;
    if (sys_w !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL wr_pre got w=%b busy=%b exp w=0 busy=1", sys_w, busy); end
    @(negedge clk);
    total++;
    if (sys_w !== 1'b1 || sys_r !== 1'b0 || sys_w_addr !== 32'h10 || sys_w_line !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL wr_strobe got w=%b r=%b a=%h d=%h exp w=1 r=0 a=10 d=a5a5a5a5", sys_w, sys_r, sys_w_addr, sys_w_line);
    end
    @(negedge clk);
    total++;
    if (sys_w !== 1'b0 || busy !== 1'b0 || sys_w_line !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL wr_post got w=%b busy=%b d=%h exp w=0 busy=0 d=a5a5a5a5", sys_w, busy, sys_w_line);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_read();
    int w;
    logic [31:0] exp;
    send(1'b0, 32'h11, 32'h0, w);
    exp = model_step(1'b0, 32'h11, 32'h0);
    @(negedge clk);
    total++;
    if (sys_r !== 1'b0) begin bad++; $display("FAIL rd_pre got r=%b exp=0", sys_r); end
    @(negedge clk);
    total++;
    if (sys_r !== 1'b1 || sys_w !== 1'b0 || sys_r_addr !== 32'h11) begin
      bad++;
      $display("FAIL rd_strobe got r=%b w=%b a=%h exp r=1 w=0 a=11", sys_r, sys_w, sys_r_addr);
    end
    @(negedge clk);
    total++;
    if (sys_r !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_wait got r=%b rsp=%b exp 0 0", sys_r, rsp_valid); end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
      bad++;
      $display("FAIL rd_rsp got v=%b d=%h exp v=1 d=%h", rsp_valid, rsp_rdata, exp);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== exp || busy !== 1'b0) begin
      bad++;
      $display("FAIL rd_after got v=%b d=%h busy=%b exp v=0 d=%h busy=0", rsp_valid, rsp_rdata, busy, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    int b, sumw;
    int waits[7];
    logic [31:0] d[5];
    b = bus_log.size();
    for (int i = 0; i < 5; i++) d[i] = $urandom;
    // Two leading reads stall popping long enough for four writes to fill the queue.
    send(1'b0, 32'h30, 32'h0, waits[0]);
    send(1'b0, 32'h31, 32'h0, waits[1]);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 32'h50 + i, d[i], waits[2+i]);
      void'(model_step(1'b1, 32'h50 + i, d[i]));
    end
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", req_ready); end
    send(1'b1, 32'h54, d[4], waits[6]);
    void'(model_step(1'b1, 32'h54, d[4]));
    sumw = 0;
    for (int i = 0; i < 6; i++) sumw += waits[i];
    total++;
    if (sumw !== 0) begin bad++; $display("FAIL fill_b2b_waits got=%0d exp=0", sumw); end
    total++;
    if (waits[6] !== 2) begin bad++; $display("FAIL fill_held_off got=%0d exp=2", waits[6]); end
    wait_idle("fill");
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus_log.size() - b !== 7) begin
      bad++;
      $display("FAIL fill_count got=%0d exp=7", bus_log.size() - b);
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (bus_log[b+2+i].we !== 1'b1 || bus_log[b+2+i].addr !== 32'h50 + i ||
            bus_log[b+2+i].data !== d[i] || bus_log[b+2+i].cyc !== bus_log[b+2].cyc + i) begin
          bad++;
          $display("FAIL fill_wr%0d got we=%b a=%h d=%h cyc=%0d exp we=1 a=%h d=%h cyc=%0d", i,
                   bus_log[b+2+i].we, bus_log[b+2+i].addr, bus_log[b+2+i].data, bus_log[b+2+i].cyc,
                   32'h50 + i, d[i], bus_log[b+2].cyc + i);
        end
      end
    end
  endtask

  task automatic test_raw();
    int b, r, w;
    logic [31:0] exp;
    b = bus_log.size();
    r = rsp_log.size();
    send(1'b1, 32'h20, 32'h1234_5678, w);
    void'(model_step(1'b1, 32'h20, 32'h1234_5678));
    send(1'b0, 32'h20, 32'h0, w);
    exp = model_step(1'b0, 32'h20, 32'h0);
    wait_idle("raw");
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rsp_log.size() - r !== 1 || bus_log.size() - b !== 2) begin
      bad++;
      $display("FAIL raw_count got rsp=%0d bus=%0d exp rsp=1 bus=2", rsp_log.size() - r, bus_log.size() - b);
    end else begin
      total++;
      if (rsp_log[r].data !== exp) begin bad++; $display("FAIL raw_data got=%h exp=%h", rsp_log[r].data, exp); end
      total++;
      if (bus_log[b].we !== 1'b1 || bus_log[b+1].we !== 1'b0 || bus_log[b].cyc >= bus_log[b+1].cyc) begin
        bad++;
        $display("FAIL raw_order got we0=%b we1=%b c0=%0d c1=%0d exp write before read",
                 bus_log[b].we, bus_log[b+1].we, bus_log[b].cyc, bus_log[b+1].cyc);
      end
    end
  endtask

  task automatic test_reset_rwait();
    int b, r, b2, r2, w;
    b = bus_log.size();
    r = rsp_log.size();
    send(1'b0, 32'h30, 32'h0, w);
    send(1'b1, 32'h60, 32'h1111_2222, w);
    send(1'b0, 32'h61, 32'h0, w);
    total++;
    if (bus_log.size() - b !== 1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_setup got strobes=%0d busy=%b exp strobes=1 busy=1", bus_log.size() - b, busy);
    end
    rst = 1'b1;
    b2 = bus_log.size();
    r2 = rsp_log.size();
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_rst got=%b exp=0", req_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if (rsp_log.size() !== r2) begin bad++; $display("FAIL rst_no_rsp got=%0d exp=%0d", rsp_log.size(), r2); end
    total++;
    if (bus_log.size() !== b2) begin bad++; $display("FAIL rst_no_strobe got=%0d exp=%0d", bus_log.size(), b2); end
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_after got ready=%b busy=%b exp ready=1 busy=0", req_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int b, r, s, w, gap, ov0;
    bit we;
    logic [31:0] a, d;
    logic [31:0] exp_rd[$];
    int rd_cyc[$];
    b = bus_log.size();
    r = rsp_log.size();
    s = sent.size();
    ov0 = overlap;
    for (int i = 0; i < 1000; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 32'h40 + $urandom_range(0, 7);
      d  = $urandom;
      send(we, a, d, w);
      if (we) void'(model_step(1'b1, a, d));
      else exp_rd.push_back(model_step(1'b0, a, d));
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle("rand");
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus_log.size() - b !== sent.size() - s) begin
      bad++;
      $display("FAIL rand_bus_count got=%0d exp=%0d", bus_log.size() - b, sent.size() - s);
    end else begin
      for (int i = 0; i < sent.size() - s; i++) begin
        total++;
        if (bus_log[b+i].we !== sent[s+i].we || bus_log[b+i].addr !== sent[s+i].addr ||
            (sent[s+i].we && bus_log[b+i].data !== sent[s+i].data)) begin
          bad++;
          $display("FAIL rand_order[%0d] got we=%b a=%h d=%h exp we=%b a=%h d=%h", i,
                   bus_log[b+i].we, bus_log[b+i].addr, bus_log[b+i].data,
                   sent[s+i].we, sent[s+i].addr, sent[s+i].data);
        end
        if (!bus_log[b+i].we) rd_cyc.push_back(bus_log[b+i].cyc);
      end
    end
    total++;
    if (rsp_log.size() - r !== exp_rd.size()) begin
      bad++;
      $display("FAIL rand_rsp_count got=%0d exp=%0d", rsp_log.size() - r, exp_rd.size());
    end else begin
      for (int k = 0; k < exp_rd.size(); k++) begin
        total++;
        if (rsp_log[r+k].data !== exp_rd[k]) begin
          bad++;
          $display("FAIL rand_rdata[%0d] got=%h exp=%h", k, rsp_log[r+k].data, exp_rd[k]);
        end
        if (k < rd_cyc.size()) begin
          total++;
          if (rsp_log[r+k].cyc !== rd_cyc[k] + 2) begin
            bad++;
            $display("FAIL rand_latency[%0d] got=%0d exp=%0d", k, rsp_log[r+k].cyc, rd_cyc[k] + 2);
          end
        end
      end
    end
    total++;
    if (overlap !== ov0 || overlap !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", overlap); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_fill();
    test_raw();
    test_reset_rwait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/periph_bus_master.md
PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, request queue depth in entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  core offers a request.
REQ-005 req_ready  output  1  queue can accept; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  peripheral word address.
REQ-008 req_wdata  input  32  write data; ignored for reads.
REQ-009 rsp_valid  output  1  one-cycle pulse: read data is valid.
REQ-010 rsp_rdata  output  32  captured read data; holds until the next capture.
REQ-011 sys_w_addr  output  32  bus write address.
REQ-012 sys_w_line  output  32  bus write data.
REQ-013 sys_w  output  1  bus write strobe.
REQ-014 sys_r_addr  output  32  bus read address.
REQ-015 sys_r  output  1  bus read strobe.
REQ-016 sys_r_line  input  32  shared read-data line, driven by the addressed peripheral.
REQ-017 busy  output  1  1 while the queue is non-empty or a bus transaction is in progress.

Function
REQ-018 The block SHALL queue requests in a FIFO of FIFO_DEPTH entries, each {we, addr, wdata}, with power-of-two pointer wrap-around.
REQ-019 req_ready SHALL be 1 exactly when the queue is not full, evaluated from registered occupancy; pushes while full are not accepted, including on an edge that also pops.
REQ-020 A simultaneous push and pop on a non-full, non-empty queue SHALL leave occupancy unchanged.
REQ-021 The FSM SHALL have states IDLE, WRITE, READ and RWAIT, and SHALL issue bus transactions strictly in queue order, one at a time.
REQ-022 IDLE or WRITE with a non-empty queue SHALL pop the head. A write head goes to WRITE; a read head goes to READ. IDLE or WRITE with an empty queue goes to IDLE.
REQ-023 WRITE: sys_w=1 for exactly one cycle, with sys_w_addr and sys_w_line equal to the popped entry. Back-to-back writes SHALL sustain one per cycle.
REQ-024 READ: sys_r=1 for exactly one cycle, with sys_r_addr equal to the popped address. The FSM then goes unconditionally to RWAIT, where sys_r=0.
REQ-025 The rising edge ending RWAIT SHALL capture sys_r_line into rsp_rdata and set rsp_valid=1 for the following cycle only. The FSM returns to IDLE, which may pop in that same cycle.
REQ-026 Read latency SHALL be fixed: rsp_valid is asserted two cycles after the cycle in which sys_r=1. No timeout is applied; an unaddressed read returns whatever sys_r_line carries.
REQ-027 sys_w and sys_r SHALL never both be 1. When no strobe is active, the address and data outputs SHALL hold their last values.
REQ-028 A read queued after a write to the same address SHALL return the written value, since the write strobe precedes the read strobe by at least one edge.
REQ-029 No pop SHALL occur while the FSM is in READ or RWAIT; pushes remain allowed while not full.
REQ-030 busy SHALL be the registered OR of (queue non-empty) and (state != IDLE).

Reset
REQ-031 With rst=1 at a rising edge, the block SHALL reset state to IDLE and empty the queue.
REQ-032 Reset values SHALL be: sys_w=0, sys_r=0, sys_w_addr=0, sys_w_line=0, sys_r_addr=0, rsp_valid=0, rsp_rdata=0, busy=0.
REQ-033 While rst=1, req_ready SHALL be 0; after release it SHALL be 1.
REQ-034 Reset in READ or RWAIT SHALL drop the in-flight read with no rsp_valid; queued entries SHALL be discarded.

Verification
REQ-035 Single write (addr 0x10, data 0xA5A5A5A5) from idle: sys_w=1 one cycle later for one cycle with those values, then busy=0.
REQ-036 Read of addr 0x11 with a model peripheral returning 0x0000_00FF registered one cycle after sys_r: sys_r high for 1 cycle, rsp_valid 2 cycles later, rsp_rdata=0x000000FF.
REQ-037 Push 4 writes back-to-back: req_ready=0 after the 4th push, a 5th request is held off, and the 4 sys_w pulses appear on consecutive cycles in push order.
REQ-038 Write 0x12345678 to 0x20, then read 0x20, using the model peripheral: rsp_rdata=0x12345678 and sys_w precedes sys_r.
REQ-039 Assert rst during RWAIT with 2 entries queued: no rsp_valid, no further strobes, req_ready=1 and busy=0 after release.
REQ-040 Random mix of 1000 requests with random req_valid gaps: bus order matches push order, strobes never overlap, and pointer wrap is exercised.
